// File: rtl/log2_arb_if.sv
// Bundle of request/response signals between requesters and the shared log2 arbiter.
// master: requester side; slave: arbiter side.
interface log2_arb_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [2:0]        rsp_log;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_log, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_log, rsp_err, busy
    );
endinterface

// File: rtl/log2_arb.sv
// Round-robin arbiter sharing one 8-bit log2 unit among NREQ requesters (IDLE/CALC/RESP).
// Define LOG2_ARB_ERR_EN to flag operands that are not an exact power of two on rsp_err.
module log2_arb #(
    parameter int unsigned NREQ = 4
) (
    input logic        clk,
    input logic        rst,
    log2_arb_if.slave  bus
);
    localparam int unsigned IW = $clog2(NREQ);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    log_q, log_d;

    logic [IW-1:0] win;
    logic          found;
    logic          onehot;
    logic [2:0]    pos;

    // First valid requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        onehot = (data_q != 8'h00) && ((data_q & (data_q - 8'd1)) == 8'h00);
        pos    = 3'd0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (data_q[k]) pos = 3'(k);
        end
    end

`ifdef LOG2_ARB_ERR_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        log_d   = log_q;
`ifdef LOG2_ARB_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = win;
                    data_d  = bus.req_data[{win, 3'b000} +: 8];
                    state_d = StCalc;
                end
            end
            StCalc: begin
                log_d   = onehot ? pos : 3'd0;
`ifdef LOG2_ARB_ERR_EN
                err_d   = !onehot;
`endif
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready[gnt_q]) begin
                    ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            log_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            log_q   <= log_d;
        end
    end

`ifdef LOG2_ARB_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // req_ready is combinational from req_valid, so it must also be held off during reset.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (!rst && (state_q == StIdle) && found) bus.req_ready[win] = 1'b1;
        if (state_q == StResp) bus.rsp_valid[gnt_q] = 1'b1;
    end

    assign bus.rsp_log = log_q;
    assign bus.busy    = (state_q != StIdle);
endmodule

// File: tb/tb_log2_arb.sv
// Self-checking bench for log2_arb: directed scenarios plus randomized operations
// checked against an arithmetic round-robin / log2 reference model.
module tb_log2_arb;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;

    log2_arb_if #(.NREQ(NREQ)) bus ();

    log2_arb #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         mptr;
    logic [2:0] prev_log;
    logic       prev_err;
    logic [7:0] data [NREQ];

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [2:0] model_log(input logic [7:0] d);
        if ($countones(d) == 1) return 3'($clog2(d));
        return 3'd0;
    endfunction

    function automatic logic model_err(input logic [7:0] d);
`ifdef LOG2_ARB_ERR_EN
        return ($countones(d) != 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = data[i];
    endtask

    // mode 0: hold inputs, 1: drop all req_valid after transfer, 2: scramble valid and data.
    task automatic run_op(input logic [NREQ-1:0] valid, input int hold, input int mode,
                          output int g);
        logic [NREQ-1:0] rr;
        logic [7:0]      d;
        bus.req_valid = valid;
        drive_data();
        #1;
        g = model_grant(valid, mptr);
        d = data[g];
        check("req_ready_grant", 32'(bus.req_ready), 32'(1 << g));
        tick();
        if (mode == 1) bus.req_valid = '0;
        if (mode == 2) begin
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) data[i] = 8'($urandom);
            drive_data();
        end
        check("calc_busy", 32'(bus.busy), 32'd1);
        check("calc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("calc_req_ready", 32'(bus.req_ready), 32'd0);
        check("calc_log_hold", 32'(bus.rsp_log), 32'(prev_log));
        check("calc_err_hold", 32'(bus.rsp_err), 32'(prev_err));
        tick();
        prev_log = model_log(d);
        prev_err = model_err(d);
        for (int h = 0; h <= hold; h++) begin
            rr    = NREQ'($urandom) | NREQ'(1);
            rr[g] = (h == hold);
            bus.rsp_ready = rr;
            check("resp_valid", 32'(bus.rsp_valid), 32'(1 << g));
            check("resp_log", 32'(bus.rsp_log), 32'(prev_log));
            check("resp_err", 32'(bus.rsp_err), 32'(prev_err));
            check("resp_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_log_hold", 32'(bus.rsp_log), 32'(prev_log));
        mptr = (g + 1) % NREQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        // Reset, with a request already pending to prove req_ready is gated.
        rst           = 1'b1;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) data[i] = 8'h00;
        drive_data();
        #3;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_log", 32'(bus.rsp_log), 32'd0);
        check("rst_err", 32'(bus.rsp_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("rst_busy_clk", 32'(bus.busy), 32'd0);
        rst      = 1'b0;
        mptr     = 0;
        prev_log = 3'd0;
        prev_err = 1'b0;

        // Single request.
        data[0] = 8'h80;
        run_op(4'b0001, 0, 0, g);

        // Round robin with all requesters continuously valid.
        for (int i = 0; i < NREQ; i++) data[i] = 8'(1 << (i + 1));
        for (int k = 0; k < 5; k++) run_op(4'b1111, 0, 0, g);

        // Backpressure on requester 2 for five cycles.
        data[2] = 8'h10;
        run_op(4'b0100, 5, 0, g);

        // Invalid and edge operands.
        data[0] = 8'h00;
        run_op(4'b0001, 0, 0, g);
        data[0] = 8'h06;
        run_op(4'b0001, 0, 0, g);
        data[0] = 8'h01;
        run_op(4'b0001, 0, 0, g);

        // Late withdrawal.
        data[0] = 8'h04;
        run_op(4'b0001, 0, 1, g);

        // Asynchronous reset in the middle of RESP.
        bus.req_valid = 4'b0010;
        bus.rsp_ready = '0;
        data[1]       = 8'h20;
        drive_data();
        #1;
        check("mid_req_ready", 32'(bus.req_ready), 32'(1 << model_grant(4'b0010, mptr)));
        tick();
        tick();
        check("mid_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_log", 32'(bus.rsp_log), 32'd0);
        check("mid_rst_err", 32'(bus.rsp_err), 32'd0);
        #1;
        rst      = 1'b0;
        mptr     = 0;
        prev_log = 3'd0;
        prev_err = 1'b0;
        data[1]  = 8'h02;
        data[3]  = 8'h40;
        run_op(4'b1010, 0, 0, g);
        run_op(4'b1010, 0, 0, g);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] v;
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 0) data[i] = 8'(1 << $urandom_range(0, 7));
                else                           data[i] = 8'($urandom);
            end
            run_op(v, $urandom_range(0, 3), $urandom_range(0, 2), g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
